// File: rtl/sram_pkg.sv
// Shared types and widths for the MEM-stage SRAM controller.
package sram_pkg;

  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_ADDR_W = 17;
  localparam int WORD_W      = 32;

  localparam int          DEFAULT_WAIT_CYCLES = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Replace one 32-bit half of a 64-bit line with a store word.
  function automatic logic [SRAM_DATA_W-1:0] merge_word(
    input logic [SRAM_DATA_W-1:0] line,
    input logic [WORD_W-1:0]      word,
    input logic                   hi
  );
    logic [SRAM_DATA_W-1:0] merged;
    merged = line;
    if (hi) merged[63:32] = word;
    else    merged[31:0]  = word;
    return merged;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Access-phase timer: counts from 0 up to WAIT_CYCLES-1 and saturates there.
// clear restarts the count from 0 on the next edge.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam int                CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count up, saturating at the terminal value so the counter never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = (r_count == LAST);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: 32-bit loads/stores onto a 64-bit line SRAM,
// stores done as read-modify-write, each phase held for WAIT_CYCLES clocks.
//
//   state  | meaning
//   IDLE   | no access; ready mirrors absence of a request
//   RD     | SRAM read phase, line sampled on the last clock
//   WR     | merged line driven, SRAM_WE_N low
//   DONE   | one-clock ready pulse back to the pipeline
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);

  state_t r_state;
  state_t w_state_nxt;

  logic                   w_req;
  logic                   w_clear;
  logic                   w_done;
  logic                   w_ready;
  logic                   w_we_n;
  logic                   w_drive;
  logic [31:0]            w_off;
  logic                   w_unused_off;
  logic [WORD_W-1:0]      w_rd_half;

  logic [SRAM_ADDR_W-1:0] r_line;
  logic                   r_hi;
  logic                   r_is_wr;
  logic [WORD_W-1:0]      r_wdata;
  logic [SRAM_DATA_W-1:0] r_wline;
  logic [WORD_W-1:0]      r_rdata;

  assign w_req = rd_en | wr_en;

  // Offset arithmetic is modulo 2^32, so addresses below BASE_ADDR simply
  // wrap to the top of the 17-bit line space.
  assign w_off        = address - BASE_ADDR;
  assign w_unused_off = ^{w_off[31:20], w_off[1:0]};

  assign w_rd_half = r_hi ? SRAM_DQ[63:32] : SRAM_DQ[31:0];

  // Restart the phase timer on every state change; hold it at 0 while idle.
  assign w_clear = (w_state_nxt != r_state) || (r_state == S_IDLE);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .done  (w_done)
  );

  // State register; async reset drops any access in progress immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and bus-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_we_n      = 1'b1;
    w_drive     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = ~w_req;
        if (w_req) w_state_nxt = S_RD;
      end
      S_RD: begin
        if (w_done) w_state_nxt = r_is_wr ? S_WR : S_DONE;
      end
      S_WR: begin
        w_we_n  = 1'b0;
        w_drive = 1'b1;
        if (w_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and read-phase capture (load result or merged store line).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line  <= '0;
      r_hi    <= 1'b0;
      r_is_wr <= 1'b0;
      r_wdata <= '0;
      r_wline <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_line  <= w_off[19:3];
        r_hi    <= w_off[2];
        r_is_wr <= wr_en;
        r_wdata <= wdata;
      end
      if (r_state == S_RD && w_done) begin
        if (r_is_wr) r_wline <= merge_word(SRAM_DQ, r_wdata, r_hi);
        else         r_rdata <= w_rd_half;
      end
    end
  end

  // DQ follows the state directly so WE_N and the data drive release together.
  assign SRAM_DQ   = w_drive ? r_wline : {SRAM_DATA_W{1'bz}};
  assign SRAM_WE_N = w_we_n;
  assign SRAM_ADDR = r_line;
  assign ready     = w_ready;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM model.
module tb_sram_controller;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  wire  [31:0] rdata;
  wire         ready;
  wire  [63:0] sram_dq;
  wire  [16:0] sram_addr;
  wire         sram_we_n;

  logic [63:0] mem [0:15];
  logic        probe;
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [63:0] pre_val;

  int checks = 0;
  int errors = 0;
  int lat, we_lo, addr_bad;

  always #5 clk = ~clk;

  sram_controller #(
    .WAIT_CYCLES (4),
    .BASE_ADDR   (32'd1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  // SRAM model: drives the addressed line while WE_N is high. In probe mode
  // it drives all zeros, so any value seen on DQ then comes from the DUT.
  assign sram_dq = sram_we_n ? (probe ? 64'h0 : mem[sram_addr[3:0]]) : 64'hz;

  // SRAM model write port, plus a bench-side preload path.
  always @(posedge clk) begin
    if (!sram_we_n)  mem[sram_addr[3:0]] <= sram_dq;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  // Issue one request, scramble address/wdata after it is latched, and run
  // until ready (bounded). Reports latency, WE_N-low cycles and address errors.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [16:0] line,
                        output int o_lat, output int o_we_lo, output int o_addr_bad);
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    wdata      = d;
    o_lat      = 0;
    o_we_lo    = 0;
    o_addr_bad = 0;
    do begin
      tick();
      o_lat++;
      if (o_lat == 1) begin
        address = 32'hFFFF_FFF0;
        wdata   = 32'h0;
      end
      if (!sram_we_n) o_we_lo++;
      if (!ready && sram_addr !== line) o_addr_bad++;
    end while (!ready && o_lat < 40);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    address = '0;
    wdata   = '0;
    probe   = 1'b1;
    pre_en  = 1'b0;
    pre_idx = '0;
    pre_val = '0;

    repeat (2) tick();
    chk("rst_ready",  {63'd0, ready},     64'd1);
    chk("rst_we_n",   {63'd0, sram_we_n}, 64'd1);
    chk("rst_dq",     sram_dq,            64'd0);
    chk("rst_rdata",  {32'd0, rdata},     64'd0);
    chk("rst_addr",   {47'd0, sram_addr}, 64'd0);

    rst   = 1'b1;
    probe = 1'b0;
    preload(4'd0,  64'h11112222_33334444);
    preload(4'd1,  64'hAAAAAAAA_55555555);
    preload(4'd15, 64'h01234567_89ABCDEF);

    // Load low half of line 0.
    rd_en = 1'b1;
    #1;
    chk("req_idle_ready", {63'd0, ready}, 64'd0);
    do_req(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, we_lo, addr_bad);
    chk("ld_lo_lat",   lat,             64'd5);
    chk("ld_lo_rdata", {32'd0, rdata},  64'h33334444);
    chk("ld_lo_addr",  addr_bad,        64'd0);
    tick();

    // Load high half of line 0.
    do_req(1'b1, 1'b0, 32'd1028, 32'h0, 17'd0, lat, we_lo, addr_bad);
    chk("ld_hi_lat",   lat,             64'd5);
    chk("ld_hi_rdata", {32'd0, rdata},  64'h11112222);
    chk("ld_hi_addr",  addr_bad,        64'd0);
    tick();

    // Store into the high half of line 1.
    do_req(1'b0, 1'b1, 32'd1036, 32'hDEADBEEF, 17'd1, lat, we_lo, addr_bad);
    chk("st_lat",      lat,             64'd9);
    chk("st_we_lo",    we_lo,           64'd4);
    chk("st_addr",     addr_bad,        64'd0);
    chk("st_rdata",    {32'd0, rdata},  64'h11112222);
    tick();
    chk("st_line1",    mem[1],          64'hDEADBEEF_55555555);

    // Reset during the write phase of a store to line 0.
    wr_en   = 1'b1;
    address = 32'd1024;
    wdata   = 32'hCAFEF00D;
    repeat (5) tick();
    chk("mid_wr_we_n", {63'd0, sram_we_n}, 64'd0);
    wr_en = 1'b0;
    probe = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n",  {63'd0, sram_we_n}, 64'd1);
    chk("mid_rst_dq",    sram_dq,            64'd0);
    chk("mid_rst_ready", {63'd0, ready},     64'd1);
    chk("mid_rst_addr",  {47'd0, sram_addr}, 64'd0);
    chk("mid_rst_rdata", {32'd0, rdata},     64'd0);
    tick();
    rst   = 1'b1;
    probe = 1'b0;
    tick();
    chk("mid_rst_line0", mem[0], 64'h11112222_33334444);

    // Load the stored word back, then a simultaneous rd/wr acts as a store.
    do_req(1'b1, 1'b0, 32'd1036, 32'h0, 17'd1, lat, we_lo, addr_bad);
    chk("ld_st_rdata", {32'd0, rdata}, 64'hDEADBEEF);
    tick();
    do_req(1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 17'd0, lat, we_lo, addr_bad);
    chk("both_lat",    lat,            64'd9);
    chk("both_we_lo",  we_lo,          64'd4);
    chk("both_rdata",  {32'd0, rdata}, 64'hDEADBEEF);
    tick();
    chk("both_line0",  mem[0],         64'h11112222_0BADF00D);

    // Back-to-back load of the word just stored.
    do_req(1'b1, 1'b0, 32'd1024, 32'h0, 17'd0, lat, we_lo, addr_bad);
    chk("b2b_lat",     lat,            64'd5);
    chk("b2b_rdata",   {32'd0, rdata}, 64'h0BADF00D);
    tick();

    // Address below BASE_ADDR wraps to the last line, high half.
    do_req(1'b1, 1'b0, 32'd1020, 32'h0, 17'h1FFFF, lat, we_lo, addr_bad);
    chk("wrap_addr",   addr_bad,       64'd0);
    chk("wrap_rdata",  {32'd0, rdata}, 64'h01234567);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1, "timeout");
  end

endmodule
